// File: rtl/lms_tap_sequencer.sv
// Control FSM for a time-multiplexed LMS filter. Each sample runs a MAC pass
// over all taps, presents the result, and optionally runs a coefficient-update pass.
module lms_tap_sequencer #(
  parameter int DEPTH = 2,
  parameter int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            adapt_en,
  output logic            shift_en,
  output logic [IDXW-1:0] tap_idx,
  output logic            mac_clr,
  output logic            mac_en,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            err_ready,
  input  logic            err_valid,
  output logic            upd_en,
  output logic            busy,
  output logic [CNTW-1:0] sample_cnt
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high. Our valids (out_valid) stay high until taken; our readies
  // (in_ready, err_ready) come from registered state only.

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FILTER   = 3'd1,
    S_OUTPUT   = 3'd2,
    S_ERR_WAIT = 3'd3,
    S_UPDATE   = 3'd4
  } state_t;

  localparam logic [IDXW-1:0] LAST_TAP = IDXW'(DEPTH - 1);

  state_t            state_q;
  state_t            state_d;
  logic [IDXW-1:0]   cnt_q;
  logic [IDXW-1:0]   cnt_d;
  logic              adapt_q;
  logic              in_ready_q;
  logic [CNTW-1:0]   sample_cnt_q;
  logic              accept;
  logic              last_tap;
  logic              sample_done;

  assign accept      = in_valid & in_ready_q;
  assign last_tap    = (cnt_q == LAST_TAP);
  assign sample_done = (state_q != S_IDLE) && (state_d == S_IDLE);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      adapt_q      <= 1'b0;
      in_ready_q   <= 1'b0;
      sample_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_ready_q <= (state_d == S_IDLE);
      if (accept) begin
        adapt_q <= adapt_en;
      end
      if (sample_done) begin
        sample_cnt_q <= sample_cnt_q + CNTW'(1);
      end
    end
  end

  // Next-state logic; the tap counter is zero whenever a pass is not running,
  // so each pass starts from tap 0 without a separate clear.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_FILTER;
        end
      end
      S_FILTER: begin
        if (last_tap) begin
          state_d = S_OUTPUT;
        end else begin
          cnt_d = cnt_q + IDXW'(1);
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          state_d = adapt_q ? S_ERR_WAIT : S_IDLE;
        end
      end
      S_ERR_WAIT: begin
        if (err_valid) begin
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (last_tap) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + IDXW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode: everything except shift_en comes from registered state.
  always_comb begin
    shift_en  = accept;
    in_ready  = in_ready_q;
    tap_idx   = '0;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    out_valid = 1'b0;
    err_ready = 1'b0;
    upd_en    = 1'b0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_FILTER: begin
        tap_idx = cnt_q;
        mac_en  = 1'b1;
        mac_clr = (cnt_q == '0);
      end
      S_OUTPUT: begin
        out_valid = 1'b1;
      end
      S_ERR_WAIT: begin
        err_ready = 1'b1;
      end
      S_UPDATE: begin
        tap_idx = cnt_q;
        upd_en  = 1'b1;
      end
      default: begin
        tap_idx = '0;
      end
    endcase
  end

  assign sample_cnt = sample_cnt_q;

  a_out_hold: assert property (@(posedge clk) disable iff (!rstn)
    (out_valid && !out_ready) |=> out_valid);
  a_accept_idle: assert property (@(posedge clk) disable iff (!rstn)
    accept |-> (state_q == S_IDLE));

endmodule

// File: tb/tb_lms_tap_sequencer.sv
// Bench for lms_tap_sequencer: a DEPTH=4/CNTW=4 and a DEPTH=1 instance, each
// checked every cycle against a transaction-level model, plus directed scenarios.
module tb_lms_tap_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  initial forever #5 clk = ~clk;

  logic in_valid [2];
  logic adapt_en [2];
  logic out_ready[2];
  logic err_valid[2];

  logic       in_ready0, shift_en0, mac_clr0, mac_en0, out_valid0, err_ready0, upd_en0, busy0;
  logic [1:0] tap_idx0;
  logic [3:0] sample_cnt0;
  logic       in_ready1, shift_en1, mac_clr1, mac_en1, out_valid1, err_ready1, upd_en1, busy1;
  logic [0:0] tap_idx1;
  logic [15:0] sample_cnt1;

  lms_tap_sequencer #(.DEPTH(4), .CNTW(4)) u_dut4 (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid[0]), .in_ready(in_ready0), .adapt_en(adapt_en[0]),
    .shift_en(shift_en0), .tap_idx(tap_idx0), .mac_clr(mac_clr0), .mac_en(mac_en0),
    .out_valid(out_valid0), .out_ready(out_ready[0]),
    .err_ready(err_ready0), .err_valid(err_valid[0]),
    .upd_en(upd_en0), .busy(busy0), .sample_cnt(sample_cnt0)
  );

  lms_tap_sequencer #(.DEPTH(1)) u_dut1 (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid[1]), .in_ready(in_ready1), .adapt_en(adapt_en[1]),
    .shift_en(shift_en1), .tap_idx(tap_idx1), .mac_clr(mac_clr1), .mac_en(mac_en1),
    .out_valid(out_valid1), .out_ready(out_ready[1]),
    .err_ready(err_ready1), .err_valid(err_valid[1]),
    .upd_en(upd_en1), .busy(busy1), .sample_cnt(sample_cnt1)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        in_ready;
    logic        shift_en;
    logic        mac_clr;
    logic        mac_en;
    logic        out_valid;
    logic        err_ready;
    logic        upd_en;
    logic        busy;
    logic [7:0]  tap;
    logic [15:0] cnt;
  } obs_t;

  // ---------------- behavioural model ----------------
  // A sample is a scripted list of per-cycle tap actions (the filter or update
  // pass) followed by open-ended waits for the output and error handshakes.
  typedef struct packed {
    logic       clr;
    logic       mac;
    logic       upd;
    logic       lastf;
    logic       lastu;
    logic [7:0] idx;
  } ent_t;

  ent_t scr_q[2][$];
  bit   m_rdy  [2];
  bit   m_wout [2];
  bit   m_werr [2];
  bit   m_adapt[2];
  int   m_cnt  [2];
  int   dep [2] = '{4, 1};
  int   cmod[2] = '{16, 65536};

  task automatic model_reset(input int k);
    scr_q[k].delete();
    m_rdy[k] = 0; m_wout[k] = 0; m_werr[k] = 0; m_adapt[k] = 0; m_cnt[k] = 0;
  endtask

  task automatic push_pass(input int k, input bit is_upd);
    for (int i = 0; i < dep[k]; i++) begin
      ent_t e;
      e.clr   = !is_upd && (i == 0);
      e.mac   = !is_upd;
      e.upd   = is_upd;
      e.lastf = !is_upd && (i == dep[k] - 1);
      e.lastu = is_upd && (i == dep[k] - 1);
      e.idx   = 8'(i);
      scr_q[k].push_back(e);
    end
  endtask

  task automatic sample_done(input int k);
    m_cnt[k] = (m_cnt[k] + 1) % cmod[k];
    m_rdy[k] = 1;
  endtask

  task automatic model_step(input int k);
    if (scr_q[k].size() > 0) begin
      ent_t e;
      e = scr_q[k].pop_front();
      if (e.lastf) m_wout[k] = 1;
      if (e.lastu) sample_done(k);
    end else if (m_wout[k]) begin
      if (out_ready[k]) begin
        m_wout[k] = 0;
        if (m_adapt[k]) m_werr[k] = 1;
        else sample_done(k);
      end
    end else if (m_werr[k]) begin
      if (err_valid[k]) begin
        m_werr[k] = 0;
        push_pass(k, 1'b1);
      end
    end else if (in_valid[k] && m_rdy[k]) begin
      m_adapt[k] = adapt_en[k];
      m_rdy[k]   = 0;
      push_pass(k, 1'b0);
    end else begin
      m_rdy[k] = 1;
    end
  endtask

  function automatic obs_t get_exp(input int k);
    obs_t e;
    e = '0;
    if (rstn) begin
      e.cnt = 16'(m_cnt[k]);
      if (scr_q[k].size() > 0) begin
        e.mac_clr = scr_q[k][0].clr;
        e.mac_en  = scr_q[k][0].mac;
        e.upd_en  = scr_q[k][0].upd;
        e.tap     = scr_q[k][0].idx;
        e.busy    = 1'b1;
      end else if (m_wout[k]) begin
        e.out_valid = 1'b1;
        e.busy      = 1'b1;
      end else if (m_werr[k]) begin
        e.err_ready = 1'b1;
        e.busy      = 1'b1;
      end else begin
        e.in_ready = m_rdy[k];
        e.shift_en = m_rdy[k] & in_valid[k];
      end
    end
    return e;
  endfunction

  function automatic obs_t get_act(input int k);
    obs_t a;
    if (k == 0) begin
      a = '{in_ready0, shift_en0, mac_clr0, mac_en0, out_valid0, err_ready0,
            upd_en0, busy0, 8'(tap_idx0), 16'(sample_cnt0)};
    end else begin
      a = '{in_ready1, shift_en1, mac_clr1, mac_en1, out_valid1, err_ready1,
            upd_en1, busy1, 8'(tap_idx1), sample_cnt1};
    end
    return a;
  endfunction

  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rstn) model_reset(k);
      else model_step(k);
    end
  end

  // ---------------- scoreboard / compare ----------------
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      obs_t ex, ac;
      if (!rstn) model_reset(k);
      ex = get_exp(k);
      ac = get_act(k);
      n_vec++;
      if (ac !== ex) begin
        n_bad++;
        $display("FAIL outputs_dut%0d @%0t: actual=%h required=%h (in_ready,shift,mac_clr,mac_en,out_valid,err_ready,upd_en,busy|tap|cnt)",
                 k, $time, ac, ex);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: actual %0d required %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 0; adapt_en[k] = 0; out_ready[k] = 0; err_valid[k] = 0;
    end
  endtask

  task automatic wait_rdy(input int k);
    int t = 0;
    while (((k == 0) ? in_ready0 : in_ready1) !== 1'b1 && t < 60) begin
      tick();
      t++;
    end
    chk($sformatf("wait_in_ready_dut%0d", k), (k == 0) ? in_ready0 : in_ready1, 1);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    rstn = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs_dut4", 32'(get_act(0)), 0);
    chk("reset_outputs_dut1", 32'(get_act(1)), 0);
    rstn = 1'b1;
    #1;
    chk("reset_release_in_ready_low", in_ready0, 0);
    tick();
    chk("in_ready_first_edge", in_ready0, 1);

    // plain filter pass
    in_valid[0] = 1; adapt_en[0] = 0; out_ready[0] = 1;
    #1 chk("s1_shift", shift_en0, 1);
    tick();
    in_valid[0] = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("s1_mac_en", mac_en0, 1);
      chk("s1_tap", tap_idx0, i);
      chk("s1_mac_clr", mac_clr0, (i == 0));
      tick();
    end
    chk("s1_out_valid", out_valid0, 1);
    tick();
    chk("s1_in_ready", in_ready0, 1);
    chk("s1_cnt", sample_cnt0, 1);
    chk("s1_model_cnt", m_cnt[0], 1);

    // adaptive pass, error arrives 3 cycles late
    in_valid[0] = 1; adapt_en[0] = 1; out_ready[0] = 1; err_valid[0] = 0;
    #1 chk("s2_shift", shift_en0, 1);
    tick();
    in_valid[0] = 0;
    repeat (4) tick();
    chk("s2_out_valid", out_valid0, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("s2_err_ready_wait", err_ready0, 1);
      chk("s2_no_upd", upd_en0, 0);
      tick();
    end
    chk("s2_err_ready_last", err_ready0, 1);
    err_valid[0] = 1;
    tick();
    err_valid[0] = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("s2_upd_en", upd_en0, 1);
      chk("s2_upd_tap", tap_idx0, i);
      tick();
    end
    chk("s2_in_ready", in_ready0, 1);
    chk("s2_cnt", sample_cnt0, 2);

    // output backpressure with a competing sample held at the input
    in_valid[0] = 1; adapt_en[0] = 0; out_ready[0] = 0;
    #1 chk("s3_shift", shift_en0, 1);
    tick();
    repeat (4) tick();
    for (int i = 0; i < 10; i++) begin
      chk("s3_out_hold", out_valid0, 1);
      chk("s3_no_shift", shift_en0, 0);
      chk("s3_in_ready_low", in_ready0, 0);
      tick();
    end
    out_ready[0] = 1;
    tick();
    in_valid[0] = 0;
    #1;
    chk("s3_in_ready", in_ready0, 1);
    chk("s3_cnt", sample_cnt0, 3);

    // reset in the middle of the update pass
    in_valid[0] = 1; adapt_en[0] = 1; out_ready[0] = 1; err_valid[0] = 1;
    tick();
    in_valid[0] = 0;
    begin
      int t = 0;
      while (!(upd_en0 === 1'b1 && tap_idx0 === 2'd2) && t < 40) begin
        tick();
        t++;
      end
      chk("s4_reach_upd_tap2", {upd_en0, tap_idx0}, {29'd0, 1'b1, 2'd2});
    end
    chk("s4_cnt_before", sample_cnt0, 3);
    rstn = 1'b0;
    #1;
    chk("s4_outputs_zero", 32'(get_act(0)), 0);
    chk("s4_busy_zero", busy0, 0);
    clear_inputs();
    tick();
    tick();
    rstn = 1'b1;
    #1 chk("s4_in_ready_before_edge", in_ready0, 0);
    tick();
    chk("s4_in_ready_after_edge", in_ready0, 1);
    chk("s4_cnt_after", sample_cnt0, 0);

    // back-to-back samples, counter wrap
    in_valid[0] = 1; out_ready[0] = 1; adapt_en[0] = 0;
    #1;
    begin
      int last = 0;
      int nacc = 0;
      int cyc  = 0;
      while (nacc < 17 && cyc < 200) begin
        if (shift_en0 === 1'b1) begin
          nacc++;
          if (nacc > 1) chk("s5_gap", cyc - last, 6);
          if (nacc == 16) chk("s5_cnt_15", sample_cnt0, 15);
          if (nacc == 17) chk("s5_cnt_wrap", sample_cnt0, 0);
          last = cyc;
        end
        tick();
        cyc++;
      end
      chk("s5_accepts", nacc, 17);
    end
    in_valid[0] = 0;
    wait_rdy(0);

    // single-tap instance with adaptation
    wait_rdy(1);
    in_valid[1] = 1; adapt_en[1] = 1; out_ready[1] = 1; err_valid[1] = 1;
    #1 chk("s6_shift", shift_en1, 1);
    tick();
    in_valid[1] = 0;
    #1;
    chk("s6_mac_clr", mac_clr1, 1);
    chk("s6_mac_en", mac_en1, 1);
    chk("s6_tap", tap_idx1, 0);
    tick();
    chk("s6_out_valid", out_valid1, 1);
    tick();
    chk("s6_err_ready", err_ready1, 1);
    tick();
    chk("s6_upd_en", upd_en1, 1);
    chk("s6_upd_tap", tap_idx1, 0);
    tick();
    chk("s6_in_ready", in_ready1, 1);
    chk("s6_upd_done", upd_en1, 0);
    chk("s6_cnt", sample_cnt1, 1);
    clear_inputs();
    tick();

    // randomized traffic with occasional reset
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        in_valid[k]  = ($urandom_range(0, 3) != 0);
        adapt_en[k]  = 1'($urandom_range(0, 1));
        out_ready[k] = ($urandom_range(0, 3) != 0);
        err_valid[k] = ($urandom_range(0, 2) == 0);
      end
      if ($urandom_range(0, 249) == 0) begin
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
      end
      tick();
    end
    clear_inputs();
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
